// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Word-addressed data memory target for the load/store path.
// - Takes one request at a time over a valid/ready handshake.
// - Spends LATENCY cycles in BUSY, then does the access.
// - Holds the response on a valid/ready channel until it is taken.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     synchronous active-low reset (clears the FSM and all words)
//   req_valid   request present
//   req_ready   responder can accept a request (IDLE only)
//   req_write   1 = store, 0 = load
//   req_addr    word address
//   req_wdata   store data
//   resp_valid  response present
//   resp_ready  requester takes the response
//   resp_rdata  load data; 0 for stores and errors
//   resp_err    address was >= DEPTH
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 20,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [3:0]          LAT4    = 4'(LATENCY);
  // One extra bit so DEPTH == 2^ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
  logic                    oor;

  assign oor = ({1'b0, addr_q} >= DEPTH_W);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ready_d      = ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_d        = mem_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = LAT4;
          ready_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          cnt_d        = '0;
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = oor;
          if (!oor) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (addr_q == ADDR_WIDTH'(i)) begin
                if (wr_q) mem_d[i]     = wdata_q;
                else      resp_rdata_d = mem_q[i];
              end
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          ready_d      = 1'b1;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_q        <= mem_d;
    end
  end

  // The registered ready is 1 in IDLE. It is masked so that the port
  // stays low while reset is held, yet reads 1 in the first cycle after release.
  assign req_ready  = ready_q & reset_n;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder servicing the load/store units of the register datapath. It sits on the memory side of the load/store path. It accepts one request at a time through a valid/ready handshake and holds a DEPTH x 20-bit word array. After a fixed access latency it completes the read or write and returns read data plus an error flag on a valid/ready response channel. It replaces the free-running array indexing used by the load/store units with a proper request/response target.

## Interface
- DATA_WIDTH, 20, word width in bits
- ADDR_WIDTH, 5, request address width
- DEPTH, 20, implemented words; legal range 1..2^ADDR_WIDTH
- LATENCY, 2, cycles spent in BUSY per access; legal range 1..15

- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  store data
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts the response
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors
- resp_err  out  1  address >= DEPTH

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - Accept = req_valid && req_ready at an edge.
  - On accept, latch write, addr and wdata, load a 4-bit counter with LATENCY, and go to BUSY.
- BUSY:
  - req_ready = 0.
  - At each edge, if counter == 1, perform the access and go to RESP. Otherwise decrement the counter.
- Access rules:
  - In-range store: mem[addr] <= wdata; resp_rdata <= 0; resp_err <= 0.
  - In-range load: resp_rdata <= mem[addr]; resp_err <= 0.
  - Out-of-range (addr >= DEPTH), load or store: no array write; resp_rdata <= 0; resp_err <= 1.
- RESP:
  - resp_valid = 1; req_ready = 0.
  - resp_rdata and resp_err are held stable until the handshake completes.
  - When resp_ready = 1 at an edge, go to IDLE and clear resp_valid, resp_rdata and resp_err.
- Exactly one outstanding request, so load/store ordering is strict program order. A load issued after a store to the same address returns the stored value.
- Request inputs are ignored outside IDLE. Changes to them during BUSY or RESP do not affect the latched request.

## Timing
- Reset (reset_n = 0 at an edge):
  - State goes to IDLE.
  - req_ready = 1 in the following cycle. While reset_n is held low, req_ready = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, counter = 0.
  - All DEPTH words are cleared to 0.
- Reset mid-operation: the in-flight request is discarded. An uncommitted store is not written, and no response is produced.
- Latency:
  - Accept at edge E0. resp_valid is first high in the cycle after edge E_LATENCY.
  - LATENCY = 1 gives a response in the cycle directly after acceptance.
- Throughput:
  - The earliest next accept is the edge after the response handshake, because IDLE must be visible for a cycle.
  - With resp_ready held at 1, one access takes LATENCY + 2 cycles.
- Backpressure: resp_ready = 0 keeps the FSM in RESP indefinitely with outputs frozen.
- Simultaneous events:
  - req_valid asserted in the same cycle as the response handshake is not accepted, because req_ready = 0 in RESP.
  - reset_n = 0 takes priority over every handshake.
- Boundaries:
  - Address DEPTH-1 is the last legal word.
  - Addresses DEPTH..2^ADDR_WIDTH-1 produce an error, with no wrap-around or aliasing.
  - With DEPTH = 2^ADDR_WIDTH, resp_err is never asserted.

## Test plan
- Reset clears memory:
  - Stimulus: after reset, with LATENCY=2, load from addresses 0, 7 and 19.
  - Response: each returns resp_rdata=0 and resp_err=0, with resp_valid high exactly 2 cycles after each accept.
- Store then load:
  - Stimulus: store 0xABCDE to addr 5, then load addr 5.
  - Response: the store returns rdata=0 and err=0; the load returns 0xABCDE.
  - Stimulus: store 0xFFFFF to addr 19, then load addr 19.
  - Response: the load returns 0xFFFFF.
- Out-of-range:
  - Stimulus: store 0x12345 to addr 20, then load addr 20 and addr 31.
  - Response: all three return err=1 and rdata=0; a load of addr 0 still returns its prior value.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 10 cycles after a load of a word holding 0x00042.
  - Response: resp_valid, rdata=0x00042 and err=0 stay constant and req_ready stays 0.
  - Stimulus: a req_valid store to addr 3 pulsed during that window.
  - Response: it is ignored, and mem[3] is unchanged.
- Reset mid-operation:
  - Stimulus: a store of 0x11111 to addr 2 is accepted, then reset_n=0 one cycle later while in BUSY with LATENCY=3.
  - Response: no response is produced, and a subsequent load of addr 2 returns 0.
- Latency sweep:
  - Stimulus: LATENCY=1 and LATENCY=15, back-to-back requests with resp_ready tied to 1.
  - Response: resp_valid rises 1 and 15 cycles after the accept respectively, giving 3 and 17 cycles per access.
